// File: rtl/vault_quorum_lock_ctrl.sv
// Quorum-authorised vault lock: synchronised switches, arming hold-off, unlock timeout, blinking LED bar.
// Define VAULT_AUDIT_EN to build the saturating unlock audit counter; otherwise unlock_count is tied to 0.
//  state        | meaning
//  LOCKED       | solenoid closed, waiting for quorum
//  ARMING       | quorum present, must stay stable for ARM_CYCLES
//  UNLOCKED     | solenoid released, LED bar blinking
//  RELEASE_WAIT | unlock timed out, waiting for P and every VP to be released
module vault_quorum_lock_ctrl #(
    parameter int NUM_VP            = 2,
    parameter int P_VP_MIN          = 1,
    parameter int OPEN_VP_MIN       = 2,
    parameter int ARM_CYCLES        = 4,
    parameter int UNLOCK_CYCLES     = 64,
    parameter int BLINK_HALF_CYCLES = 8,
    parameter int LED_W             = 7,
    parameter int AUDIT_W           = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        P,
    input  logic [NUM_VP-1:0]           VP,
    input  logic                        Open,
    output logic [LED_W-1:0]            LED,
    output logic                        Unlock,
    output logic                        timeout,
    output logic [$clog2(NUM_VP+1)-1:0] vp_count,
    output logic [AUDIT_W-1:0]          unlock_count
);
    localparam int VPC_W   = $clog2(NUM_VP + 1);
    localparam int ARM_W   = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam int HOLD_W  = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;

    localparam logic [ARM_W-1:0]   ARM_LAST   = ARM_W'(ARM_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(UNLOCK_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOCKED       = 2'd0,
        ST_ARMING       = 2'd1,
        ST_UNLOCKED     = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    logic              r_p_s1, r_p_s2;
    logic              r_o_s1, r_o_s2;
    logic [NUM_VP-1:0] r_vp_s1, r_vp_s2;
    logic [VPC_W-1:0]  r_vp_count;
    logic [VPC_W-1:0]  w_vp_pop;

    state_t             r_state;
    logic [ARM_W-1:0]   r_arm_cnt;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic [LED_W-1:0]   r_led;
    logic               r_unlock;
    logic               r_timeout;

    logic w_auth;
    logic w_arm_done;
    logic w_timeout_hit;
    logic w_all_released;

    // Popcount is taken from stage 1 so the registered count lines up with stage 2.
    always_comb begin
        w_vp_pop = '0;
        for (int i = 0; i < NUM_VP; i++) begin
            w_vp_pop = w_vp_pop + VPC_W'(r_vp_s1[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_s1     <= 1'b0;
            r_p_s2     <= 1'b0;
            r_o_s1     <= 1'b0;
            r_o_s2     <= 1'b0;
            r_vp_s1    <= '0;
            r_vp_s2    <= '0;
            r_vp_count <= '0;
        end else begin
            r_p_s1     <= P;
            r_p_s2     <= r_p_s1;
            r_o_s1     <= Open;
            r_o_s2     <= r_o_s1;
            r_vp_s1    <= VP;
            r_vp_s2    <= r_vp_s1;
            r_vp_count <= w_vp_pop;
        end
    end

    assign w_auth = (r_p_s2 && (int'(r_vp_count) >= P_VP_MIN))
                 || (r_o_s2 && r_p_s2)
                 || (r_o_s2 && (int'(r_vp_count) >= OPEN_VP_MIN));

    assign w_arm_done     = (r_state == ST_ARMING) && w_auth && (r_arm_cnt == ARM_LAST);
    assign w_timeout_hit  = (UNLOCK_CYCLES != 0) && (r_hold_cnt == HOLD_LAST);
    assign w_all_released = !r_p_s2 && (r_vp_s2 == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_LOCKED;
            r_arm_cnt   <= '0;
            r_hold_cnt  <= '0;
            r_blink_cnt <= '0;
            r_led       <= '0;
            r_unlock    <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                ST_LOCKED: begin
                    if (w_auth) begin
                        r_state   <= ST_ARMING;
                        r_arm_cnt <= '0;
                    end
                end
                ST_ARMING: begin
                    if (!w_auth) begin
                        r_state <= ST_LOCKED;
                    end else if (w_arm_done) begin
                        r_state     <= ST_UNLOCKED;
                        r_hold_cnt  <= '0;
                        r_blink_cnt <= '0;
                        r_led       <= '1;
                        r_unlock    <= 1'b1;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + ARM_W'(1);
                    end
                end
                ST_UNLOCKED: begin
                    // Loss of quorum wins over a coincident timeout.
                    if (!w_auth) begin
                        r_state  <= ST_LOCKED;
                        r_unlock <= 1'b0;
                        r_led    <= '0;
                    end else if (w_timeout_hit) begin
                        r_state   <= ST_RELEASE_WAIT;
                        r_unlock  <= 1'b0;
                        r_led     <= '0;
                        r_timeout <= 1'b1;
                    end else begin
                        if (UNLOCK_CYCLES != 0) begin
                            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                        end
                        if (r_blink_cnt == BLINK_LAST) begin
                            r_blink_cnt <= '0;
                            r_led       <= ~r_led;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
                        end
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (w_all_released) begin
                        r_state   <= ST_LOCKED;
                        r_timeout <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_LOCKED;
                end
            endcase
        end
    end

`ifdef VAULT_AUDIT_EN
    logic [AUDIT_W-1:0] r_unlock_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_unlock_count <= '0;
        end else if (w_arm_done && (r_unlock_count != '1)) begin
            r_unlock_count <= r_unlock_count + AUDIT_W'(1);
        end
    end

    assign unlock_count = r_unlock_count;
`else
    assign unlock_count = '0;
`endif

    assign LED      = r_led;
    assign Unlock   = r_unlock;
    assign timeout  = r_timeout;
    assign vp_count = r_vp_count;
endmodule
